// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk_in cycles.
// Reports once per input period with a one-cycle valid, and sets a sticky flag on stall.
module period_meter #(
  parameter int CNT_W   = 27,
  parameter int TIMEOUT = 100_000_000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             measuring
);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [2:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hcnt_reg, hcnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic             valid_reg, valid_next;
  logic             timeout_reg, timeout_next;

  logic s2, s3, rise, at_limit;

  // Only sync_reg[0] may go metastable; everything downstream uses s2/s3.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) sync_reg <= 3'b000;
    else     sync_reg <= {sync_reg[1:0], sig_in};
  end

  assign s2       = sync_reg[1];
  assign s3       = sync_reg[2];
  assign rise     = s2 & ~s3;
  assign at_limit = (cnt_reg == LIMIT);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // A rise coinciding with the last allowed count is still a measurement.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rise) state_next = MEASURE;
      MEASURE: if (!rise && at_limit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    measuring = (state_reg == MEASURE);
  end

  always_comb begin
    cnt_next     = cnt_reg;
    hcnt_next    = hcnt_reg;
    period_next  = period_reg;
    high_next    = high_reg;
    valid_next   = 1'b0;
    timeout_next = timeout_reg;
    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        hcnt_next = rise ? ONE : '0;
      end
      MEASURE: begin
        if (rise) begin
          period_next  = cnt_reg + ONE;
          high_next    = hcnt_reg;
          valid_next   = 1'b1;
          timeout_next = 1'b0;
          cnt_next     = '0;
          hcnt_next    = ONE;
        end else if (at_limit) begin
          timeout_next = 1'b1;
          cnt_next     = '0;
          hcnt_next    = '0;
        end else begin
          cnt_next  = cnt_reg + ONE;
          hcnt_next = hcnt_reg + {{(CNT_W-1){1'b0}}, s2};
        end
      end
      default: begin
        cnt_next  = '0;
        hcnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      hcnt_reg    <= '0;
      period_reg  <= '0;
      high_reg    <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      hcnt_reg    <= hcnt_next;
      period_reg  <= period_next;
      high_reg    <= high_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
    end
  end

  assign period    = period_reg;
  assign high_time = high_reg;
  assign valid     = valid_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: directed and random square waves against an
// index-arithmetic model of the synchronised input, plus literal spot checks.
module tb_period_meter;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 20;
  localparam int HMAX    = 8192;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             measuring;

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .measuring (measuring)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rel    = 0;
  int vtotal = 0;
  bit hist [HMAX];

  // Model state: the cycle of the last rise and what has been reported.
  bit m_meas, m_timeout, exp_valid;
  int m_last, m_period, m_high;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Synchronised input as seen in cycle c: two cycles late, zero until refilled after reset.
  function automatic bit s2_at(input int c);
    if (c - 2 < rel) return 1'b0;
    return hist[c-2];
  endfunction

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  initial begin : monitor
    int c;
    int h;
    bit r;
    forever begin
      @(negedge clk_in);
      c = cyc;
      if (c < HMAX) hist[c] = sig_in;
      if (rst) begin
        chk("rst_valid", int'(valid), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_timeout", int'(timeout), 0);
        m_meas = 0; m_timeout = 0; m_period = 0; m_high = 0; exp_valid = 0; m_last = 0;
        rel = c;
      end else begin
        chk("valid", int'(valid), int'(exp_valid));
        chk("period", int'(period), m_period);
        chk("high_time", int'(high_time), m_high);
        chk("timeout", int'(timeout), int'(m_timeout));
        chk("measuring", int'(measuring), int'(m_meas));
        vtotal += int'(valid);
        r = s2_at(c) & ~s2_at(c - 1);
        exp_valid = 1'b0;
        if (!m_meas) begin
          if (r) begin
            m_meas = 1'b1;
            m_last = c;
          end
        end else if (r) begin
          h = 0;
          for (int k = m_last; k < c; k++) h += int'(s2_at(k));
          exp_valid = 1'b1;
          m_period  = c - m_last;
          m_high    = h;
          m_timeout = 1'b0;
          m_last    = c;
        end else if (c - m_last == TIMEOUT) begin
          m_timeout = 1'b1;
          m_meas    = 1'b0;
        end
      end
    end
  end

  task automatic drive(input bit v);
    @(posedge clk_in);
    #1;
    sig_in = v;
  endtask

  task automatic wave(input int per, input int hi, input int count);
    for (int p = 0; p < count; p++)
      for (int k = 0; k < per; k++) drive(k < hi);
  endtask

  initial begin : stim
    int snap;
    int p;
    int h;
    repeat (3) @(posedge clk_in);
    #1;
    chk("init_period", int'(period), 0);
    chk("init_measuring", int'(measuring), 0);
    @(negedge clk_in);
    #2 rst = 1'b0;

    // Six edges from IDLE: first only arms, five reports.
    snap = vtotal;
    wave(10, 5, 6);
    chk("sq_valid_count", vtotal - snap, 5);
    chk("sq_period", int'(period), 10);
    chk("sq_high", int'(high_time), 5);
    chk("sq_measuring", int'(measuring), 1);

    wave(12, 3, 4);
    chk("duty3_period", int'(period), 12);
    chk("duty3_high", int'(high_time), 3);
    wave(12, 9, 4);
    chk("duty9_high", int'(high_time), 9);

    // Stall: last edge at k=0, rise two cycles later, flag visible 21 cycles after the rise.
    wave(10, 5, 3);
    for (int k = 0; k < 30; k++) begin
      drive(k < 5);
      if (k == 22) chk("stall_early", int'(timeout), 0);
      if (k == 23) begin
        chk("stall_timeout", int'(timeout), 1);
        chk("stall_measuring", int'(measuring), 0);
        chk("stall_period", int'(period), 10);
      end
    end
    snap = vtotal;
    wave(10, 5, 1);
    chk("rearm_timeout", int'(timeout), 1);
    chk("rearm_no_valid", vtotal - snap, 0);
    chk("rearm_measuring", int'(measuring), 1);
    wave(10, 5, 1);
    chk("resume_timeout", int'(timeout), 0);
    chk("resume_valid", vtotal - snap, 1);
    chk("resume_period", int'(period), 10);

    wave(20, 10, 3);
    chk("bound20_period", int'(period), 20);
    chk("bound20_timeout", int'(timeout), 0);
    wave(21, 10, 3);
    chk("bound21_timeout", int'(timeout), 1);
    chk("bound21_period", int'(period), 20);

    // Reset four cycles after a rise cycle, asserted between edges.
    for (int k = 0; k < 7; k++) drive(k < 5);
    @(negedge clk_in);
    #2 rst = 1'b1;
    #1;
    chk("async_period", int'(period), 0);
    chk("async_high", int'(high_time), 0);
    chk("async_timeout", int'(timeout), 0);
    chk("async_measuring", int'(measuring), 0);
    drive(1'b0);
    drive(1'b0);
    @(negedge clk_in);
    #2 rst = 1'b0;
    snap = vtotal;
    for (int k = 0; k < 20; k++) begin
      drive((k % 10) < 5);
      if (k == 5) chk("post_rst_arm", int'(measuring), 1);
      if (k == 12) chk("post_rst_no_valid", vtotal - snap, 0);
      if (k == 13) begin
        chk("post_rst_valid", int'(valid), 1);
        chk("post_rst_period", int'(period), 10);
        chk("post_rst_high", int'(high_time), 5);
      end
    end

    for (int i = 0; i < 50; i++) begin
      p = int'($urandom_range(24, 2));
      h = int'($urandom_range(p - 1, 1));
      wave(p, h, 1);
    end
    repeat (30) drive(1'b0);
    chk("final_timeout", int'(timeout), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
